// File: rtl/clk_gen_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | clk_gen_pkg : ratio legality check and width helper for clock gens.  |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package clk_gen_pkg;

    // Odd ratios only; even ratios need a different (single-edge) divider.
    function automatic bit div_is_legal(input int div);
        return (div >= 3) && ((div % 2) == 1);
    endfunction

    function automatic int cnt_width(input int div);
        return $clog2(div);
    endfunction

endpackage : clk_gen_pkg
`default_nettype wire

// File: rtl/clk_div_odd_cnt.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | clk_div_odd_cnt : modulo-DIV counter, async reset to DIV-1.          |
// | Revision        : 1.0                                                |
// +----------------------------------------------------------------------+
module clk_div_odd_cnt
    import clk_gen_pkg::*;
#(
    parameter int DIV = 3,
    parameter int CW  = cnt_width(DIV)
) (
    input  logic          clk,
    input  logic          rst,
    output logic [CW-1:0] cnt,
    output logic [CW-1:0] cnt_nxt
);

    localparam logic [CW-1:0] C_LAST = CW'(DIV - 1);

    always_comb begin
        cnt_nxt = (cnt == C_LAST) ? '0 : cnt + CW'(1);
    end

    // Resetting to the last value makes the first post-reset edge a wrap to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= C_LAST;
        end else begin
            cnt <= cnt_nxt;
        end
    end

endmodule : clk_div_odd_cnt
`default_nettype wire

// File: rtl/clk_div_odd.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | clk_div_odd : odd-ratio clock divider with exact 50% duty cycle.     |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module clk_div_odd
    import clk_gen_pkg::*;
#(
    parameter int DIV = 3
) (
    input  logic clk,
    input  logic rst,
    output logic clk_out
);

    localparam int            CW     = cnt_width(DIV);
    localparam logic [CW-1:0] C_HALF = CW'((DIV - 1) / 2);
    localparam logic [CW-1:0] C_DIV  = CW'(DIV);

    generate
        if (!div_is_legal(DIV)) begin : g_bad_div
            $fatal(1, "clk_div_odd: DIV=%0d is illegal, must be odd and >= 3", DIV);
        end
    endgenerate

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          q_pos;
    logic          q_neg;

    clk_div_odd_cnt #(
        .DIV (DIV),
        .CW  (CW)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .cnt     (cnt),
        .cnt_nxt (cnt_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_pos <= 1'b0;
        end else begin
            q_pos <= (cnt_nxt < C_HALF);
        end
    end

    // Half-cycle delayed copy supplies the extra half period of high time.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            q_neg <= 1'b0;
        end else begin
            q_neg <= q_pos;
        end
    end

    assign clk_out = q_pos | q_neg;

    a_cnt_range : assert property (@(posedge clk) disable iff (rst) cnt < C_DIV);

endmodule : clk_div_odd
`default_nettype wire

// File: tb/tb_clk_div_odd.sv
`default_nettype none
`timescale 1ns/1ps
// Bench for clk_div_odd: three dividers (3, 5, 7) against a half-cycle-count model.
module tb_clk_div_odd;

    logic       clk = 1'b0;
    logic [2:0] rst_v = 3'b111;
    wire  [2:0] co;

    int checks = 0;
    int errors = 0;

    int divs [3] = '{3, 5, 7};
    bit started [3];
    int h [3];
    bit prev_clk = 1'b0;

    bit duty_en = 1'b1;
    bit have_last = 1'b0;
    longint last_t = 0;

    always #5 clk = ~clk;

    clk_div_odd #(.DIV(3)) u_d3 (.clk(clk), .rst(rst_v[0]), .clk_out(co[0]));
    clk_div_odd #(.DIV(5)) u_d5 (.clk(clk), .rst(rst_v[1]), .clk_out(co[1]));
    clk_div_odd #(.DIV(7)) u_d7 (.clk(clk), .rst(rst_v[2]), .clk_out(co[2]));

    // Model: output is high for the first DIV half-cycles of every 2*DIV,
    // counted from the first posedge seen with reset low.
    always @(posedge clk or negedge clk or posedge rst_v[0] or posedge rst_v[1] or posedge rst_v[2]) begin
        for (int i = 0; i < 3; i++) begin
            if (rst_v[i]) started[i] = 1'b0;
        end
        if (clk !== prev_clk) begin
            for (int i = 0; i < 3; i++) begin
                if (clk) begin
                    if (!rst_v[i]) begin
                        if (!started[i]) begin
                            started[i] = 1'b1;
                            h[i] = 0;
                        end else begin
                            h[i] = h[i] + 1;
                        end
                    end
                end else if (started[i]) begin
                    h[i] = h[i] + 1;
                end
            end
            prev_clk = clk;
        end
    end

    function automatic bit expv(input int i);
        return !rst_v[i] && started[i] && ((h[i] % (2 * divs[i])) < divs[i]);
    endfunction

    task automatic check(input string name, input bit act, input bit req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, req);
        end
    endtask

    always @(posedge clk or negedge clk) begin
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("clk_out_div%0d", divs[i]), co[i], expv(i));
        end
    end

    always @(co[2]) begin
        if (duty_en && $time >= 25) begin
            if (have_last) begin
                checks++;
                if (($time - last_t) != 35) begin
                    errors++;
                    $display("FAIL duty7 at %0t: interval %0d ns, expected 35 ns", $time, $time - last_t);
                end
            end
            last_t = $time;
            have_last = 1'b1;
        end
    end

    task automatic pin(input string name, input int i, input bit lit);
        check({name, "_model"}, expv(i), lit);
        check({name, "_dut"}, co[i], lit);
    endtask

    initial begin
        #20 rst_v = 3'b000;
        #7  pin("d3_t27_high", 0, 1'b1);
            pin("d5_t27_high", 1, 1'b1);
        #15 pin("d3_t42_low", 0, 1'b0);
            pin("d5_t42_high", 1, 1'b1);
        #5  rst_v[0] = 1'b1;
        #1  pin("d3_t48_rst", 0, 1'b0);
        #4  pin("d5_t52_low", 1, 1'b0);
        #5  pin("d7_t57_high", 2, 1'b1);
        #5  rst_v[0] = 1'b0;
        #1  pin("d7_t63_low", 2, 1'b0);
            pin("d3_t63_wait", 0, 1'b0);
        #4  pin("d3_t67_high", 0, 1'b1);
        #10 pin("d3_t77_high", 0, 1'b1);
        #5  pin("d3_t82_low", 0, 1'b0);
        #718;
        duty_en = 1'b0;

        for (int n = 0; n < 25; n++) begin
            logic [2:0] sel;
            sel = 3'($urandom_range(1, 7));
            repeat ($urandom_range(2, 30)) @(posedge clk);
            #($urandom_range(2, 4));
            rst_v = rst_v | sel;
            #1;
            for (int i = 0; i < 3; i++) begin
                if (sel[i]) check($sformatf("async_rst_div%0d", divs[i]), co[i], 1'b0);
            end
            repeat ($urandom_range(0, 6)) @(negedge clk);
            if ($urandom_range(0, 1) == 1) @(posedge clk);
            else @(negedge clk);
            #($urandom_range(2, 4));
            rst_v = 3'b000;
        end
        repeat (40) @(posedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_clk_div_odd
`default_nettype wire
